// File: rtl/mips_cpu_bus.sv
// Non-pipelined multicycle MIPS32 subset core with a stallable word bus.
// Each instruction passes FETCH -> FETCH_WAIT -> EXEC, and loads and stores also pass through MEM / MEM_WAIT.
module mips_cpu_bus (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    MEM        = 3'd3,
    MEM_WAIT   = 3'd4,
    HALTED     = 3'd5
  } state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, ir_q, ir_d;
  logic [31:0] address_q, address_d, writedata_q, writedata_d;
  logic        read_q, read_d, write_q, write_d, active_q, active_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] gpr_q [32];

  logic        gpr_we_s;
  logic [4:0]  gpr_wa_s;
  logic [31:0] gpr_wd_s;

  logic [31:0] instr_s, rs_val_s, rt_val_s, simm_s, zimm_s, pc4_s, ea_s, br_tgt_s;
  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s;

  // In EXEC the instruction is decoded straight off readdata. In the states after EXEC it comes from ir_q.
  assign instr_s  = (state_q == EXEC) ? readdata : ir_q;
  assign op_s     = instr_s[31:26];
  assign rs_s     = instr_s[25:21];
  assign rt_s     = instr_s[20:16];
  assign rd_s     = instr_s[15:11];
  assign funct_s  = instr_s[5:0];
  assign rs_val_s = gpr_q[rs_s];
  assign rt_val_s = gpr_q[rt_s];
  assign simm_s   = {{16{instr_s[15]}}, instr_s[15:0]};
  assign zimm_s   = {16'h0000, instr_s[15:0]};
  assign pc4_s    = pc_q + 32'd4;
  assign ea_s     = rs_val_s + simm_s;
  assign br_tgt_s = pc4_s + (simm_s << 2);

  // Next-state, bus request and register-write decode
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    npc_d        = npc_q;
    ir_d         = ir_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    read_d       = read_q;
    write_d      = write_q;
    active_d     = active_q;
    byteenable_d = 4'b1111;
    gpr_we_s     = 1'b0;
    gpr_wa_s     = 5'd0;
    gpr_wd_s     = 32'd0;
    case (state_q)
      FETCH: begin
        if (pc_q == 32'd0) begin
          state_d  = HALTED;
          active_d = 1'b0;
          read_d   = 1'b0;
          write_d  = 1'b0;
        end else begin
          state_d   = FETCH_WAIT;
          read_d    = 1'b1;
          address_d = pc_q;
        end
      end
      FETCH_WAIT: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          state_d = EXEC;
        end else begin
          state_d = FETCH_WAIT;
        end
      end
      EXEC: begin
        ir_d    = readdata;
        pc_d    = npc_q;
        npc_d   = npc_q + 32'd4;
        state_d = FETCH;
        case (op_s)
          6'h00: begin
            gpr_wa_s = rd_s;
            case (funct_s)
              6'h08: npc_d = rs_val_s;
              6'h21: begin gpr_we_s = 1'b1; gpr_wd_s = rs_val_s + rt_val_s; end
              6'h23: begin gpr_we_s = 1'b1; gpr_wd_s = rs_val_s - rt_val_s; end
              6'h24: begin gpr_we_s = 1'b1; gpr_wd_s = rs_val_s & rt_val_s; end
              6'h25: begin gpr_we_s = 1'b1; gpr_wd_s = rs_val_s | rt_val_s; end
              6'h26: begin gpr_we_s = 1'b1; gpr_wd_s = rs_val_s ^ rt_val_s; end
              6'h2A: begin gpr_we_s = 1'b1; gpr_wd_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)}; end
              6'h2B: begin gpr_we_s = 1'b1; gpr_wd_s = {31'd0, rs_val_s < rt_val_s}; end
              default: gpr_we_s = 1'b0;
            endcase
          end
          6'h09: begin gpr_we_s = 1'b1; gpr_wa_s = rt_s; gpr_wd_s = rs_val_s + simm_s; end
          6'h0A: begin gpr_we_s = 1'b1; gpr_wa_s = rt_s; gpr_wd_s = {31'd0, $signed(rs_val_s) < $signed(simm_s)}; end
          6'h0B: begin gpr_we_s = 1'b1; gpr_wa_s = rt_s; gpr_wd_s = {31'd0, rs_val_s < simm_s}; end
          6'h0C: begin gpr_we_s = 1'b1; gpr_wa_s = rt_s; gpr_wd_s = rs_val_s & zimm_s; end
          6'h0D: begin gpr_we_s = 1'b1; gpr_wa_s = rt_s; gpr_wd_s = rs_val_s | zimm_s; end
          6'h0E: begin gpr_we_s = 1'b1; gpr_wa_s = rt_s; gpr_wd_s = rs_val_s ^ zimm_s; end
          6'h0F: begin gpr_we_s = 1'b1; gpr_wa_s = rt_s; gpr_wd_s = {instr_s[15:0], 16'h0000}; end
          6'h23: begin
            state_d   = MEM;
            read_d    = 1'b1;
            address_d = {ea_s[31:2], 2'b00};
          end
          6'h2B: begin
            state_d     = MEM;
            write_d     = 1'b1;
            address_d   = {ea_s[31:2], 2'b00};
            writedata_d = rt_val_s;
          end
          6'h04: begin
            if (rs_val_s == rt_val_s) npc_d = br_tgt_s;
            else                      npc_d = npc_q + 32'd4;
          end
          6'h05: begin
            if (rs_val_s != rt_val_s) npc_d = br_tgt_s;
            else                      npc_d = npc_q + 32'd4;
          end
          6'h02: npc_d = {pc4_s[31:28], instr_s[25:0], 2'b00};
          6'h03: begin
            npc_d    = {pc4_s[31:28], instr_s[25:0], 2'b00};
            gpr_we_s = 1'b1;
            gpr_wa_s = 5'd31;
            gpr_wd_s = pc_q + 32'd8;
          end
          default: gpr_we_s = 1'b0;
        endcase
      end
      MEM: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = read_q ? MEM_WAIT : FETCH;
        end else begin
          state_d = MEM;
        end
      end
      MEM_WAIT: begin
        gpr_we_s = 1'b1;
        gpr_wa_s = rt_s;
        gpr_wd_s = readdata;
        state_d  = FETCH;
      end
      HALTED: begin
        state_d  = HALTED;
        active_d = 1'b0;
        read_d   = 1'b0;
        write_d  = 1'b0;
      end
      default: state_d = FETCH;
    endcase
  end

  // State, bus outputs and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_VECTOR;
      npc_q        <= RESET_VECTOR + 32'd4;
      ir_q         <= 32'd0;
      address_q    <= RESET_VECTOR;
      writedata_q  <= 32'd0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      active_q     <= 1'b1;
      byteenable_q <= 4'b1111;
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      ir_q         <= ir_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      active_q     <= active_d;
      byteenable_q <= byteenable_d;
      if (gpr_we_s && (gpr_wa_s != 5'd0)) gpr_q[gpr_wa_s] <= gpr_wd_s;
    end
  end

  assign active      = active_q;
  assign register_v0 = gpr_q[2];
  assign address     = address_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = writedata_q;
  assign byteenable  = byteenable_q;

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Bench for mips_cpu_bus: a stalling word memory plus an instruction-level reference interpreter.
module tb_mips_cpu_bus;
  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam int MW = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;
  logic        active, read, write;
  logic [31:0] register_v0, address, writedata;
  logic [3:0]  byteenable;

  logic [31:0] mem [MW];
  logic [31:0] model_mem [MW];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        stall_en = 1'b0;
  logic        seen_write = 1'b0;

  mips_cpu_bus dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return (off < 32'(MW)) ? int'(off) : -1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < MW; i++) mem[i] = 32'd0;
  endtask

  // Instruction-set interpreter over a copy of the memory image. It returns the final $2.
  task automatic model_run(output logic [31:0] v0);
    logic [31:0] r [32];
    logic [31:0] pc, npc, nxt, ins, a, b, si, zi;
    int k, steps;
    for (int i = 0; i < MW; i++) model_mem[i] = mem[i];
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    pc = BASE; npc = BASE + 32'd4; steps = 0;
    while (pc != 32'd0 && steps < 2000) begin
      k   = widx(pc);
      ins = (k >= 0) ? model_mem[k] : 32'd0;
      a   = r[ins[25:21]];
      b   = r[ins[20:16]];
      si  = {{16{ins[15]}}, ins[15:0]};
      zi  = {16'h0000, ins[15:0]};
      nxt = npc + 32'd4;
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h08: nxt = a;
          6'h21: r[ins[15:11]] = a + b;
          6'h23: r[ins[15:11]] = a - b;
          6'h24: r[ins[15:11]] = a & b;
          6'h25: r[ins[15:11]] = a | b;
          6'h26: r[ins[15:11]] = a ^ b;
          6'h2A: r[ins[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: r[ins[15:11]] = (a < b) ? 32'd1 : 32'd0;
          default: ;
        endcase
        6'h09: r[ins[20:16]] = a + si;
        6'h0A: r[ins[20:16]] = ($signed(a) < $signed(si)) ? 32'd1 : 32'd0;
        6'h0B: r[ins[20:16]] = (a < si) ? 32'd1 : 32'd0;
        6'h0C: r[ins[20:16]] = a & zi;
        6'h0D: r[ins[20:16]] = a | zi;
        6'h0E: r[ins[20:16]] = a ^ zi;
        6'h0F: r[ins[20:16]] = {ins[15:0], 16'h0000};
        6'h23: begin k = widx(a + si); r[ins[20:16]] = (k >= 0) ? model_mem[k] : 32'd0; end
        6'h2B: begin k = widx(a + si); if (k >= 0) model_mem[k] = b; end
        6'h04: if (a == b) nxt = pc + 32'd4 + (si << 2);
        6'h05: if (a != b) nxt = pc + 32'd4 + (si << 2);
        6'h02: nxt = {pc[31:28], ins[25:0], 2'b00};
        6'h03: begin nxt = {pc[31:28], ins[25:0], 2'b00}; r[31] = pc + 32'd8; end
        default: ;
      endcase
      r[0] = 32'd0;
      pc = npc; npc = nxt; steps++;
    end
    v0 = r[2];
  endtask

  // Memory slave: random stalls, read data delivered one edge after acceptance, hold checks while stalled.
  task automatic bus_responder();
    logic held, pend, hr, hw;
    logic [31:0] ha, hd;
    int pidx, k;
    held = 1'b0; pend = 1'b0; pidx = -1;
    hr = 1'b0; hw = 1'b0; ha = 32'd0; hd = 32'd0;
    forever begin
      @(negedge clk);
      if (pend) begin
        readdata = (pidx >= 0) ? mem[pidx] : 32'd0;
        pend = 1'b0;
      end
      if (reset) begin
        held = 1'b0;
        waitrequest = 1'b0;
      end else begin
        if (held) begin
          n_checks++;
          if (address !== ha || read !== hr || write !== hw || writedata !== hd) begin
            n_fail++;
            $display("FAIL stall_hold: got addr=%h r=%b w=%b wd=%h, required addr=%h r=%b w=%b wd=%h",
                     address, read, write, writedata, ha, hr, hw, hd);
          end
        end
        if (read || write) begin
          n_checks++;
          if (read && write) begin
            n_fail++;
            $display("FAIL rw_exclusive: read=%b write=%b, required not both", read, write);
          end
        end
        waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
        if ((read || write) && !waitrequest) begin
          held = 1'b0;
          k = widx(address);
          if (write) begin
            seen_write = 1'b1;
            n_checks++;
            if (byteenable !== 4'b1111) begin
              n_fail++;
              $display("FAIL write_byteenable: got %b, required 1111", byteenable);
            end
            if (k >= 0) mem[k] = writedata;
          end
          if (read) begin
            readdata = $urandom();
            pend = 1'b1;
            pidx = k;
          end
        end else if (read || write) begin
          held = 1'b1; ha = address; hr = read; hw = write; hd = writedata;
        end else begin
          held = 1'b0;
        end
      end
    end
  endtask

  initial bus_responder();

  task automatic run_dut(input int budget);
    int k;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = 0;
    while (active !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_timeout: active=%b after %0d cycles, required 0", active, k);
    end
  endtask

  task automatic load_slt(input logic [31:0] w11, input logic [31:0] w12, input logic [31:0] last);
    clear_mem();
    mem[0]  = enc_i(6'h0F, 5'd0, 5'd8, 16'hBFC0);
    mem[1]  = enc_i(6'h23, 5'd8, 5'd9, 16'h002C);
    mem[2]  = enc_i(6'h23, 5'd8, 5'd10, 16'h0030);
    mem[3]  = enc_r(5'd0, 5'd0, 5'd0, 6'h08);
    mem[4]  = last;
    mem[11] = w11;
    mem[12] = w12;
  endtask

  task automatic test_reset();
    load_slt(32'd1, 32'd2, enc_r(5'd10, 5'd9, 5'd2, 6'h2A));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (active !== 1'b1 || read !== 1'b0 || write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: active=%b read=%b write=%b, required 1 0 0", active, read, write);
    end
    n_checks++;
    if (byteenable !== 4'b1111 || writedata !== 32'd0 || register_v0 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: be=%b wd=%h v0=%h, required 1111 0 0", byteenable, writedata, register_v0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (read !== 1'b1 || address !== BASE) begin
      n_fail++;
      $display("FAIL first_fetch: read=%b addr=%h, required 1 %h", read, address, BASE);
    end
  endtask

  task automatic test_slt();
    logic [31:0] w11 [4];
    logic [31:0] ins [4];
    logic [31:0] exp [4];
    w11 = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ins = '{enc_r(5'd10, 5'd9, 5'd2, 6'h2A), enc_r(5'd9, 5'd10, 5'd2, 6'h2A),
            enc_r(5'd9, 5'd10, 5'd2, 6'h2A), enc_r(5'd9, 5'd10, 5'd2, 6'h2B)};
    exp = '{32'd0, 32'd1, 32'd1, 32'd0};
    for (int i = 0; i < 4; i++) begin
      load_slt(w11[i], 32'd2, ins[i]);
      run_dut(500);
      n_checks++;
      if (register_v0 !== exp[i]) begin
        n_fail++;
        $display("FAIL slt_case%0d: v0=%h, required %h", i, register_v0, exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    stall_en = 1'b1;
    load_slt(32'd1, 32'd2, enc_r(5'd9, 5'd10, 5'd2, 6'h2A));
    run_dut(2000);
    n_checks++;
    if (register_v0 !== 32'd1) begin
      n_fail++;
      $display("FAIL stall_v0: v0=%h, required 1", register_v0);
    end
    stall_en = 1'b0;
  endtask

  task automatic test_store_load();
    clear_mem();
    mem[0] = enc_i(6'h0F, 5'd0, 5'd8, 16'hBFC0);
    mem[1] = enc_i(6'h0F, 5'd0, 5'd9, 16'hDEAD);
    mem[2] = enc_i(6'h0D, 5'd9, 5'd9, 16'hBEEF);
    mem[3] = enc_i(6'h2B, 5'd8, 5'd9, 16'h0080);
    mem[4] = enc_i(6'h23, 5'd8, 5'd2, 16'h0080);
    mem[5] = enc_r(5'd0, 5'd0, 5'd0, 6'h08);
    seen_write = 1'b0;
    stall_en = 1'b1;
    run_dut(2000);
    stall_en = 1'b0;
    n_checks++;
    if (register_v0 !== 32'hDEAD_BEEF || mem[32] !== 32'hDEAD_BEEF || seen_write !== 1'b1) begin
      n_fail++;
      $display("FAIL store_load: v0=%h mem=%h wr=%b, required deadbeef deadbeef 1",
               register_v0, mem[32], seen_write);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [2];
    logic [31:0] exp [2];
    ops = '{6'h04, 6'h05};
    exp = '{32'd1, 32'd2};
    for (int i = 0; i < 2; i++) begin
      clear_mem();
      mem[0] = enc_i(ops[i], 5'd0, 5'd0, 16'h0002);
      mem[1] = enc_i(6'h09, 5'd2, 5'd2, 16'h0001);
      mem[2] = enc_i(6'h09, 5'd2, 5'd2, 16'h0001);
      mem[3] = enc_r(5'd0, 5'd0, 5'd0, 6'h08);
      run_dut(500);
      repeat (5) @(negedge clk);
      n_checks++;
      if (register_v0 !== exp[i] || active !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
        n_fail++;
        $display("FAIL branch_op%h: v0=%h active=%b rd=%b wr=%b, required %h 0 0 0",
                 ops[i], register_v0, active, read, write, exp[i]);
      end
    end
  endtask

  task automatic test_jal();
    logic [31:0] tgt;
    tgt = BASE + 32'd20;
    clear_mem();
    mem[0] = {6'h03, tgt[27:2]};
    mem[2] = enc_i(6'h09, 5'd2, 5'd2, 16'h0001);
    mem[5] = enc_r(5'd31, 5'd0, 5'd2, 6'h21);
    mem[6] = enc_r(5'd0, 5'd0, 5'd0, 6'h08);
    run_dut(500);
    n_checks++;
    if (register_v0 !== BASE + 32'd8) begin
      n_fail++;
      $display("FAIL jal_link: v0=%h, required %h", register_v0, BASE + 32'd8);
    end
  endtask

  task automatic gen_random_prog();
    logic [5:0] rfn [7];
    logic [5:0] iop [7];
    logic [4:0] d, s, t;
    int w;
    rfn = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};
    iop = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    clear_mem();
    w = 0;
    for (int r = 1; r <= 7; r++) begin
      mem[w] = enc_i(6'h0F, 5'd0, 5'(r), 16'($urandom())); w++;
      mem[w] = enc_i(6'h0D, 5'(r), 5'(r), 16'($urandom())); w++;
    end
    for (int i = 0; i < 13; i++) begin
      d = 5'($urandom_range(0, 7));
      s = 5'($urandom_range(0, 7));
      t = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) mem[w] = enc_r(s, t, d, rfn[$urandom_range(0, 6)]);
      else                           mem[w] = enc_i(iop[$urandom_range(0, 6)], s, d, 16'($urandom()));
      w++;
      if (i == 11) begin
        mem[w] = enc_r(5'd0, 5'd0, 5'd0, 6'h08);
        w++;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int n = 0; n < 6; n++) begin
      gen_random_prog();
      model_run(exp);
      stall_en = (n % 2) == 1;
      run_dut(3000);
      stall_en = 1'b0;
      n_checks++;
      if (register_v0 !== exp) begin
        n_fail++;
        $display("FAIL random_prog%0d: v0=%h, required %h", n, register_v0, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    int k;
    gen_random_prog();
    model_run(exp);
    stall_en = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (active !== 1'b1 || read !== 1'b0 || write !== 1'b0 || register_v0 !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_state: active=%b rd=%b wr=%b v0=%h, required 1 0 0 0",
               active, read, write, register_v0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (read !== 1'b1 || address !== BASE) begin
      n_fail++;
      $display("FAIL midreset_fetch: read=%b addr=%h, required 1 %h", read, address, BASE);
    end
    k = 0;
    while (active !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    stall_en = 1'b0;
    n_checks++;
    if (active !== 1'b0 || register_v0 !== exp) begin
      n_fail++;
      $display("FAIL midreset_rerun: active=%b v0=%h, required 0 %h", active, register_v0, exp);
    end
  endtask

  initial begin
    test_reset();
    test_slt();
    test_stall();
    test_store_load();
    test_branch();
    test_jal();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
